// File: rtl/exp1_op_issuer.sv
// Issues one exp1 operation per host command (start + A, then B), waits for done, returns the result.
// Optional WAIT_DONE timeout abort is built when EXP1_ISSUER_TIMEOUT_EN is defined.
module exp1_op_issuer #(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             start,
  output logic [WIDTH-1:0] d_in,
  output logic [1:0]       op_code,
  input  logic             done,
  input  logic [WIDTH-1:0] res_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       rsp_op,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_DONE, RESP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] b_reg;
  logic             take_done, take_timeout;
  logic             cnt_hit;

`ifdef EXP1_ISSUER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // wait_cnt holds the number of WAIT_DONE cycles already completed
  assign cnt_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt <= '0;
    else if (state == SEND_B)
      wait_cnt <= '0;
    else if (state == WAIT_DONE)
      wait_cnt <= wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      rsp_err <= 1'b0;
    else if (take_done)
      rsp_err <= 1'b0;
    else if (take_timeout)
      rsp_err <= 1'b1;
  end
`else
  assign cnt_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    take_done    = 1'b0;
    take_timeout = 1'b0;
    case (state)
      IDLE:      if (cmd_valid) state_nxt = SEND_A;
      SEND_A:    state_nxt = SEND_B;
      SEND_B:    state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        // done is only honoured here, so a level left over from the last op is ignored
        if (done) begin
          take_done = 1'b1;
          state_nxt = RESP;
        end else if (cnt_hit) begin
          take_timeout = 1'b1;
          state_nxt    = RESP;
        end
      end
      RESP:      if (rsp_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      start     <= 1'b0;
      d_in      <= '0;
      op_code   <= '0;
      b_reg     <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= '0;
    end else begin
      state     <= state_nxt;
      start     <= (state_nxt == SEND_A);
      cmd_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      rsp_valid <= (state_nxt == RESP);
      if (state == IDLE && cmd_valid) begin
        d_in    <= cmd_a;
        op_code <= cmd_op;
        b_reg   <= cmd_b;
      end
      if (state == SEND_A)
        d_in <= b_reg;
      if (take_done) begin
        rsp_data <= res_in;
        rsp_op   <= op_code;
      end else if (take_timeout) begin
        rsp_data <= '0;
        rsp_op   <= op_code;
      end
    end
  end

endmodule

// File: tb/tb_exp1_op_issuer.sv
// Directed bench for exp1_op_issuer; timeout cases are included when EXP1_ISSUER_TIMEOUT_EN is defined.
module tb_exp1_op_issuer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_a, cmd_b;
  logic         start;
  logic [W-1:0] d_in;
  logic [1:0]   op_code;
  logic         done;
  logic [W-1:0] res_in;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic [1:0]   rsp_op;
  logic         rsp_err;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int prev_start = -100;

  exp1_op_issuer #(.WIDTH(W), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .start(start), .d_in(d_in), .op_code(op_code),
    .done(done), .res_in(res_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_op(rsp_op), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start"},     start,     0);
    chk({tag, "_d_in"},      d_in,      0);
    chk({tag, "_op_code"},   op_code,   0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"},  rsp_data,  0);
    chk({tag, "_rsp_op"},    rsp_op,    0);
    chk({tag, "_rsp_err"},   rsp_err,   0);
    chk({tag, "_busy"},      busy,      0);
  endtask

  // Full operation with done in the first WAIT_DONE cycle and immediate response accept
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] res);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    tick();
    cmd_valid = 1'b0;
    chk("op_start", start, 1);
    chk("op_dA", d_in, a);
    chk("op_code", op_code, op);
    chk("op_busy", busy, 1);
    chk("op_cmd_ready", cmd_ready, 0);
    chk("start_gap", ((cyc - prev_start) >= 5), 1);
    prev_start = cyc;
    tick();
    chk("op_start_low", start, 0);
    chk("op_dB", d_in, b);
    tick();
    chk("op_wait_no_rsp", rsp_valid, 0);
    chk("op_wait_dB", d_in, b);
    done = 1'b1; res_in = res;
    tick();
    done = 1'b0;
    chk("op_rsp_valid", rsp_valid, 1);
    chk("op_rsp_data", rsp_data, res);
    chk("op_rsp_op", rsp_op, op);
    chk("op_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("op_idle_ready", cmd_ready, 1);
    chk("op_idle_rsp", rsp_valid, 0);
    chk("op_idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    done = 1'b0; res_in = '0; rsp_ready = 1'b0;

    tick(); tick();
    rst = 1'b0;
    chk_reset_vals("reset");

    // single add, then d_in/op_code hold their last values in IDLE
    run_op(2'b00, 16'd3, 16'd1, 16'd4);
    chk("idle_hold_d_in", d_in, 1);

    // four ops back-to-back at minimum spacing
    run_op(2'b00, 16'd3, 16'd1, 16'd4);
    run_op(2'b01, 16'd3, 16'd1, 16'd2);
    run_op(2'b10, 16'd3, 16'd1, 16'd3);
    run_op(2'b11, 16'd3, 16'd1, 16'd3);
    chk("idle_hold_op", op_code, 3);

    // response backpressure with a competing command that must be ignored
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_a = 16'h00A0; cmd_b = 16'h000B;
    tick(); cmd_valid = 1'b0;
    tick(); tick();
    done = 1'b1; res_in = 16'hBEEF;
    tick(); done = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 16'h1111; cmd_b = 16'h2222;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, 16'hBEEF);
      chk("bp_rsp_op", rsp_op, 2'b01);
      chk("bp_cmd_ready", cmd_ready, 0);
      tick();
    end
    chk("bp_d_in_unchanged", d_in, 16'h000B);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_idle_ready", cmd_ready, 1);
    chk("bp_idle_rsp", rsp_valid, 0);

    // stale done held through accept, SEND_A and SEND_B
    done = 1'b1; res_in = 16'h00AA;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 16'd5; cmd_b = 16'd6;
    tick(); cmd_valid = 1'b0;
    chk("stale_start", start, 1);
    tick();
    chk("stale_sendb_rsp", rsp_valid, 0);
    tick();
    chk("stale_wait_rsp", rsp_valid, 0);
    done = 1'b0;
    tick();
    chk("stale_wait2_rsp", rsp_valid, 0);
    tick();
    chk("stale_wait3_rsp", rsp_valid, 0);
    done = 1'b1; res_in = 16'h1234;
    tick(); done = 1'b0;
    chk("stale_rsp_valid", rsp_valid, 1);
    chk("stale_rsp_data", rsp_data, 16'h1234);
    chk("stale_rsp_op", rsp_op, 2'b10);
    rsp_ready = 1'b1;
    tick(); rsp_ready = 1'b0;

    // reset pulsed in WAIT_DONE
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_a = 16'd9; cmd_b = 16'd7;
    tick(); cmd_valid = 1'b0;
    tick(); tick();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("mid_rst");
    done = 1'b1; res_in = 16'h7777;
    tick(); done = 1'b0;
    chk("mid_no_rsp", rsp_valid, 0);
    chk("mid_ready", cmd_ready, 1);

`ifdef EXP1_ISSUER_TIMEOUT_EN
    // done arriving on the last allowed WAIT_DONE cycle wins over the timeout
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_a = 16'd1; cmd_b = 16'd2;
    tick(); cmd_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 7; i++) begin
      chk("dw_wait_rsp", rsp_valid, 0);
      tick();
    end
    done = 1'b1; res_in = 16'h0055;
    tick(); done = 1'b0;
    chk("dw_rsp_valid", rsp_valid, 1);
    chk("dw_rsp_err", rsp_err, 0);
    chk("dw_rsp_data", rsp_data, 16'h0055);
    rsp_ready = 1'b1;
    tick(); rsp_ready = 1'b0;

    // no done at all: abort after 8 WAIT_DONE cycles
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_a = 16'd7; cmd_b = 16'd9;
    tick(); cmd_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 7; i++) begin
      chk("to_wait_rsp", rsp_valid, 0);
      tick();
    end
    chk("to_wait8_rsp", rsp_valid, 0);
    tick();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_data", rsp_data, 0);
    chk("to_rsp_op", rsp_op, 2'b11);
    rsp_ready = 1'b1;
    tick(); rsp_ready = 1'b0;
    chk("to_idle_ready", cmd_ready, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
